// File: rtl/irig_time_pkg.sv
// Shared constants and types for the UART time-set frame path and the IRIG-B blocks.
// Covers frame header bytes, payload length, error causes and parser states.
package irig_time_pkg;

   localparam logic [7:0] HEADER_1    = 8'hAA;
   localparam logic [7:0] HEADER_2    = 8'h55;
   localparam int         PAYLOAD_LEN = 6;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_CHECKSUM = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      HDR2,
      PAYLOAD,
      CHECK,
      VALIDATE
   } parser_state_t;

   function automatic logic bcd_digit_ok(input logic [3:0] digit);
      return digit <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational range check of a BCD time-of-year.
// Shared by the UART frame parser and the IRIG-B decoder.
module bcd_time_check
   import irig_time_pkg::*;
(
   input  logic [7:0]  sec,
   input  logic [7:0]  min,
   input  logic [7:0]  hour,
   input  logic [11:0] day,
   input  logic [7:0]  year,
   output logic        range_ok
);

   logic digits_ok;

   // Once every nibble is a decimal digit, BCD values compare correctly as plain binary.
   assign digits_ok = bcd_digit_ok(sec[7:4])   && bcd_digit_ok(sec[3:0])  &&
                      bcd_digit_ok(min[7:4])   && bcd_digit_ok(min[3:0])  &&
                      bcd_digit_ok(hour[7:4])  && bcd_digit_ok(hour[3:0]) &&
                      bcd_digit_ok(day[11:8])  && bcd_digit_ok(day[7:4])  &&
                      bcd_digit_ok(day[3:0])   &&
                      bcd_digit_ok(year[7:4])  && bcd_digit_ok(year[3:0]);

   assign range_ok = digits_ok &&
                     (sec  <= 8'h59) && (min <= 8'h59) && (hour <= 8'h23) &&
                     (day  != 12'h000) && (day <= 12'h366);

endmodule

// File: rtl/uart_time_frame_parser.sv
// Assembles 9-byte time-set frames from the UART byte stream, validates them
// and presents a BCD time to the IRIG-B encoder load port.
module uart_time_frame_parser
   import irig_time_pkg::*;
#(
   parameter int CLK_FREQ      = 50_000_000,
   parameter int UART_BPS      = 9600,
   parameter int TIMEOUT_BYTES = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  in_data,
   input  logic        in_flag,
   output logic [7:0]  time_sec,
   output logic [7:0]  time_min,
   output logic [7:0]  time_hour,
   output logic [11:0] time_day,
   output logic [7:0]  time_year,
   output logic        time_valid,
   output logic        time_loaded,
   output logic        frame_err,
   output logic [1:0]  err_code
);

   localparam longint TIMEOUT_CYC =
      longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_FREQ) / longint'(UART_BPS);
   localparam int             GAP_W    = $clog2(TIMEOUT_CYC);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0]     IDX_LAST = 3'(PAYLOAD_LEN - 1);

   parser_state_t    state, state_next;
   logic [GAP_W-1:0] gap_cnt;
   logic [2:0]       byte_idx;
   logic [7:0]       shadow [PAYLOAD_LEN];
   logic [7:0]       sum;
   logic             csum_ok;
   logic             gap_expired;
   logic             timeout_hit;
   logic             range_ok;
   logic             day_hi_ok;

   assign gap_expired = (gap_cnt == GAP_LAST);
   assign day_hi_ok   = (shadow[3][7:4] == 4'h0);

   bcd_time_check u_range (
      .sec      (shadow[0]),
      .min      (shadow[1]),
      .hour     (shadow[2]),
      .day      ({shadow[3][3:0], shadow[4]}),
      .year     (shadow[5]),
      .range_ok (range_ok)
   );

   // A byte arriving on the terminal-count cycle takes priority over the timeout.
   always_comb begin
      state_next  = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (in_flag && in_data == HEADER_1) state_next = HDR2;
         end
         HDR2: begin
            if (in_flag) begin
               if (in_data == HEADER_2)      state_next = PAYLOAD;
               else if (in_data != HEADER_1) state_next = IDLE;
            end else if (gap_expired) begin
               state_next  = IDLE;
               timeout_hit = 1'b1;
            end
         end
         PAYLOAD: begin
            if (in_flag) begin
               if (byte_idx == IDX_LAST) state_next = CHECK;
            end else if (gap_expired) begin
               state_next  = IDLE;
               timeout_hit = 1'b1;
            end
         end
         CHECK: begin
            if (in_flag) begin
               state_next = VALIDATE;
            end else if (gap_expired) begin
               state_next  = IDLE;
               timeout_hit = 1'b1;
            end
         end
         VALIDATE: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= IDLE;
         gap_cnt     <= '0;
         byte_idx    <= '0;
         sum         <= '0;
         csum_ok     <= 1'b0;
         for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= '0;
         time_sec    <= '0;
         time_min    <= '0;
         time_hour   <= '0;
         time_day    <= '0;
         time_year   <= '0;
         time_valid  <= 1'b0;
         time_loaded <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         state      <= state_next;
         time_valid <= 1'b0;
         frame_err  <= 1'b0;

         // Gap counter only runs while a frame is open and restarts on any byte or state change.
         if (in_flag || state_next != state || state == IDLE || state == VALIDATE)
            gap_cnt <= '0;
         else if (gap_cnt != '1)
            gap_cnt <= gap_cnt + GAP_W'(1);

         if (state == HDR2 && state_next == PAYLOAD) begin
            byte_idx <= '0;
            sum      <= '0;
         end

         if (state == PAYLOAD && in_flag) begin
            shadow[byte_idx] <= in_data;
            sum              <= sum + in_data;
            byte_idx         <= byte_idx + 3'd1;
         end

         if (state == CHECK && in_flag) csum_ok <= (in_data == sum);

         if (timeout_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
         end

         if (state == VALIDATE) begin
            if (!csum_ok) begin
               frame_err <= 1'b1;
               err_code  <= ERR_CHECKSUM;
            end else if (!(range_ok && day_hi_ok)) begin
               frame_err <= 1'b1;
               err_code  <= ERR_RANGE;
            end else begin
               time_sec    <= shadow[0];
               time_min    <= shadow[1];
               time_hour   <= shadow[2];
               time_day    <= {shadow[3][3:0], shadow[4]};
               time_year   <= shadow[5];
               time_valid  <= 1'b1;
               time_loaded <= 1'b1;
            end
         end
      end
   end

endmodule
